// File: rtl/pipe_hzd_ctrl.sv
// rtl/pipe_hzd_ctrl.sv - hazard, forwarding and redirect control over a shadow tag pipeline
// Optional PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module pipe_hzd_ctrl #(
    parameter int AW       = 5,
    parameter int NSTAGE   = 3,
    parameter int LD_STAGE = 3,
    parameter int FW       = $clog2(NSTAGE + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [AW-1:0] id_wraddr,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_jump,
    input  logic          ex_redirect,
    output logic [1:0]    pc_sel,
    output logic          pc_hold,
    output logic          ifid_hold,
    output logic          ifid_flush,
    output logic          idex_flush,
    output logic [FW-1:0] fwd_rs,
    output logic [FW-1:0] fwd_rt,
    output logic          id_byp_rs,
    output logic          id_byp_rt
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   flush_cnt
`endif
);

    logic          valid_q    [1:NSTAGE];
    logic [AW-1:0] wraddr_q   [1:NSTAGE];
    logic          regwrite_q [1:NSTAGE];
    logic          memread_q  [1:NSTAGE];
    // Source operands only matter while the instruction sits in EX
    logic [AW-1:0] rs1_q;
    logic [AW-1:0] rt1_q;
    logic          use_rs1_q;
    logic          use_rt1_q;

    logic          live [1:NSTAGE];
    logic          stall;
    logic          capture;

    always_comb begin
        for (int s = 1; s <= NSTAGE; s++) begin
            live[s] = valid_q[s] && regwrite_q[s] && (wraddr_q[s] != '0);
        end
    end

    assign capture = id_valid && !stall && !ex_redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 1; s <= NSTAGE; s++) begin
                valid_q[s]    <= 1'b0;
                wraddr_q[s]   <= '0;
                regwrite_q[s] <= 1'b0;
                memread_q[s]  <= 1'b0;
            end
            rs1_q     <= '0;
            rt1_q     <= '0;
            use_rs1_q <= 1'b0;
            use_rt1_q <= 1'b0;
        end else begin
            valid_q[1]    <= capture;
            wraddr_q[1]   <= capture ? id_wraddr : '0;
            regwrite_q[1] <= capture && id_regwrite;
            memread_q[1]  <= capture && id_memread;
            rs1_q         <= capture ? id_rs : '0;
            rt1_q         <= capture ? id_rt : '0;
            use_rs1_q     <= capture && id_use_rs;
            use_rt1_q     <= capture && id_use_rt;
            for (int s = 2; s <= NSTAGE; s++) begin
                valid_q[s]    <= valid_q[s-1];
                wraddr_q[s]   <= wraddr_q[s-1];
                regwrite_q[s] <= regwrite_q[s-1];
                memread_q[s]  <= memread_q[s-1];
            end
        end
    end

    // Loads before LD_STAGE-1 cannot reach EX in time even through forwarding
    always_comb begin
        stall = 1'b0;
        for (int s = 1; s <= NSTAGE; s++) begin
            if ((s < LD_STAGE - 1) && live[s] && memread_q[s] && id_valid &&
                ((id_use_rs && (wraddr_q[s] == id_rs)) ||
                 (id_use_rt && (wraddr_q[s] == id_rt)))) begin
                stall = 1'b1;
            end
        end
    end

    // Walk oldest to youngest so the youngest matching writer wins
    always_comb begin
        fwd_rs = '0;
        fwd_rt = '0;
        for (int s = NSTAGE; s >= 2; s--) begin
            if (live[s] && (!memread_q[s] || (s >= LD_STAGE)) && valid_q[1]) begin
                if (use_rs1_q && (wraddr_q[s] == rs1_q)) fwd_rs = FW'(s);
                if (use_rt1_q && (wraddr_q[s] == rt1_q)) fwd_rt = FW'(s);
            end
        end
    end

    assign id_byp_rs = live[NSTAGE] && id_use_rs && (wraddr_q[NSTAGE] == id_rs);
    assign id_byp_rt = live[NSTAGE] && id_use_rt && (wraddr_q[NSTAGE] == id_rt);

    always_comb begin
        pc_sel     = 2'd0;
        pc_hold    = 1'b0;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (ex_redirect) begin
            pc_sel     = 2'd2;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (stall) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_flush = 1'b1;
        end else if (id_jump) begin
            pc_sel     = 2'd1;
            ifid_flush = 1'b1;
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && !ex_redirect && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if ((ifid_flush || idex_flush) && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hzd_ctrl.sv
// tb/tb_pipe_hzd_ctrl.sv - directed vector bench for pipe_hzd_ctrl (default and NSTAGE=5/LD_STAGE=4)
module tb_pipe_hzd_ctrl;

    typedef struct {
        logic        v;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urs;
        logic        urt;
        logic [4:0]  wr;
        logic        rw;
        logic        mr;
        logic        jmp;
        logic        rd;
        logic [13:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       id_use_rs = 1'b0;
    logic       id_use_rt = 1'b0;
    logic [4:0] id_wraddr = '0;
    logic       id_regwrite = 1'b0;
    logic       id_memread = 1'b0;
    logic       id_jump = 1'b0;
    logic       ex_redirect = 1'b0;

    logic [1:0] a_pc_sel, b_pc_sel;
    logic       a_pc_hold, a_ifid_hold, a_ifid_flush, a_idex_flush, a_byp_rs, a_byp_rt;
    logic       b_pc_hold, b_ifid_hold, b_ifid_flush, b_idex_flush, b_byp_rs, b_byp_rt;
    logic [1:0] a_fwd_rs, a_fwd_rt;
    logic [2:0] b_fwd_rs, b_fwd_rt;
`ifdef PERF_CNT_EN
    logic [31:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hzd_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wraddr(id_wraddr),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_jump(id_jump),
        .ex_redirect(ex_redirect), .pc_sel(a_pc_sel), .pc_hold(a_pc_hold),
        .ifid_hold(a_ifid_hold), .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush),
        .fwd_rs(a_fwd_rs), .fwd_rt(a_fwd_rt), .id_byp_rs(a_byp_rs), .id_byp_rt(a_byp_rt)
`ifdef PERF_CNT_EN
        , .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
`endif
    );

    pipe_hzd_ctrl #(.NSTAGE(5), .LD_STAGE(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wraddr(id_wraddr),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_jump(id_jump),
        .ex_redirect(ex_redirect), .pc_sel(b_pc_sel), .pc_hold(b_pc_hold),
        .ifid_hold(b_ifid_hold), .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush),
        .fwd_rs(b_fwd_rs), .fwd_rt(b_fwd_rt), .id_byp_rs(b_byp_rs), .id_byp_rt(b_byp_rt)
`ifdef PERF_CNT_EN
        , .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
`endif
    );

    logic [13:0] act_a, act_b;
    assign act_a = {a_pc_sel, a_pc_hold, a_ifid_hold, a_ifid_flush, a_idex_flush,
                    1'b0, a_fwd_rs, 1'b0, a_fwd_rt, a_byp_rs, a_byp_rt};
    assign act_b = {b_pc_sel, b_pc_hold, b_ifid_hold, b_ifid_flush, b_idex_flush,
                    b_fwd_rs, b_fwd_rt, b_byp_rs, b_byp_rt};

    function automatic logic [13:0] E(input int ps, hold, ifl, idf, frs, frt, brs, brt);
        return {2'(ps), 1'(hold), 1'(hold), 1'(ifl), 1'(idf), 3'(frs), 3'(frt), 1'(brs), 1'(brt)};
    endfunction

    function automatic vec_t V(input int v, rs, rt, urs, urt, wr, rw, mr, jmp, rd, input logic [13:0] e);
        vec_t r;
        r.v = 1'(v);   r.rs = 5'(rs); r.rt = 5'(rt); r.urs = 1'(urs); r.urt = 1'(urt);
        r.wr = 5'(wr); r.rw = 1'(rw); r.mr = 1'(mr); r.jmp = 1'(jmp); r.rd = 1'(rd);
        r.exp = e;
        return r;
    endfunction

    task automatic drive(input vec_t t);
        id_valid = t.v;   id_rs = t.rs;       id_rt = t.rt;
        id_use_rs = t.urs; id_use_rt = t.urt;  id_wraddr = t.wr;
        id_regwrite = t.rw; id_memread = t.mr; id_jump = t.jmp; ex_redirect = t.rd;
    endtask

    task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %04h expected %04h", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // A load still short of LD_STAGE must never be a forwarding candidate for EX
    always @(negedge clk) begin
        if (rst_n && dut_a.valid_q[1] && dut_a.valid_q[2] && dut_a.regwrite_q[2] &&
            dut_a.memread_q[2] && dut_a.wraddr_q[2] != 5'd0 &&
            ((dut_a.use_rs1_q && dut_a.wraddr_q[2] == dut_a.rs1_q) ||
             (dut_a.use_rt1_q && dut_a.wraddr_q[2] == dut_a.rt1_q))) begin
            errors++;
            $display("FAIL early_load_a: load in stage 2 matches EX source");
        end
        for (int s = 2; s < 4; s++) begin
            if (rst_n && dut_b.valid_q[1] && dut_b.valid_q[s] && dut_b.regwrite_q[s] &&
                dut_b.memread_q[s] && dut_b.wraddr_q[s] != 5'd0 &&
                ((dut_b.use_rs1_q && dut_b.wraddr_q[s] == dut_b.rs1_q) ||
                 (dut_b.use_rt1_q && dut_b.wraddr_q[s] == dut_b.rt1_q))) begin
                errors++;
                $display("FAIL early_load_b: load in stage %0d matches EX source", s);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tab[24];
    vec_t idle, lw2, add3, xrd2;

    initial begin
        idle = V(0,0,0,0,0, 0,0,0,0,0, E(0,0,0,0,0,0,0,0));
        lw2  = V(1,1,2,1,0, 2,1,1,0,0, E(0,0,0,0,0,0,0,0));
        add3 = V(1,2,4,1,1, 3,1,0,0,0, E(0,0,0,0,0,0,0,0));
        xrd2 = V(1,2,7,1,1, 0,0,0,0,0, E(0,0,0,0,0,0,0,0));

        tab[0]  = idle;
        tab[1]  = lw2;
        tab[2]  = V(1,2,4,1,1, 3,1,0,0,0, E(0,1,0,1,0,0,0,0));
        tab[3]  = add3;
        tab[4]  = V(1,2,7,1,1, 0,0,0,0,0, E(0,0,0,0,3,0,1,0));
        tab[5]  = idle;
        tab[6]  = idle;
        tab[7]  = V(1,1,1,1,1, 2,1,0,0,0, E(0,0,0,0,0,0,0,0));
        tab[8]  = V(1,2,2,1,1, 5,1,0,0,0, E(0,0,0,0,0,0,0,0));
        tab[9]  = V(0,0,0,0,0, 0,0,0,0,0, E(0,0,0,0,2,2,0,0));
        tab[10] = V(1,1,1,1,1, 2,1,0,0,0, E(0,0,0,0,0,0,0,0));
        tab[11] = V(1,9,9,1,1, 8,1,0,0,0, E(0,0,0,0,0,0,0,0));
        tab[12] = V(1,2,2,1,1, 5,1,0,0,0, E(0,0,0,0,0,0,0,0));
        tab[13] = V(0,0,0,0,0, 0,0,0,0,0, E(0,0,0,0,3,3,0,0));
        tab[14] = V(1,1,1,1,1, 0,1,0,0,0, E(0,0,0,0,0,0,0,0));
        tab[15] = V(1,0,0,1,1, 3,1,0,0,0, E(0,0,0,0,0,0,0,0));
        tab[16] = idle;
        tab[17] = V(1,0,0,1,1, 0,0,0,0,0, E(0,0,0,0,0,0,0,0));
        tab[18] = V(1,1,4,1,0, 4,1,1,0,0, E(0,0,0,0,0,0,0,0));
        tab[19] = V(1,4,4,1,1, 6,1,0,0,1, E(2,0,1,1,0,0,0,0));
        tab[20] = V(1,1,4,1,0, 4,1,1,0,0, E(0,0,0,0,0,0,0,0));
        tab[21] = V(1,4,0,1,0, 31,1,0,1,0, E(0,1,0,1,0,0,1,0));
        tab[22] = V(1,4,0,1,0, 31,1,0,1,0, E(1,0,1,0,0,0,0,0));
        tab[23] = V(0,0,0,0,0, 0,0,0,0,0, E(0,0,0,0,3,0,0,0));

        drive(idle);
        repeat (2) @(negedge clk);
        chk("reset_a", act_a, 14'h0);
        chk("reset_b", act_b, 14'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            drive(tab[i]);
            #1;
            chk($sformatf("vec%0d", i), act_a, tab[i].exp);
        end

        // Asynchronous reset while a load-use stall is pending
        @(negedge clk); drive(idle);
        @(negedge clk); drive(lw2);
        @(negedge clk); drive(add3); #1;
        chk("pre_reset_stall", act_a, E(0,1,0,1,0,0,0,0));
        #2 rst_n = 1'b0; #1;
        chk("mid_reset_a", act_a, 14'h0);
        chk("mid_reset_b", act_b, 14'h0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("post_reset_a", act_a, 14'h0);

`ifdef PERF_CNT_EN
        chk32("stall_cnt_reset", a_stall_cnt, 32'd0);
        chk32("flush_cnt_reset", a_flush_cnt, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive(lw2);
            @(negedge clk); drive(add3);
            @(negedge clk); drive(add3);
        end
        @(negedge clk); drive(idle); ex_redirect = 1'b1;
        @(negedge clk); ex_redirect = 1'b1;
        @(negedge clk); drive(idle); #1;
        chk32("stall_cnt", a_stall_cnt, 32'd3);
        // stall cycles also bubble ID_EX, so they count as flushes
        chk32("flush_cnt", a_flush_cnt, 32'd5);
`endif

        // Deeper pipe: two-cycle load-use stall, then late forward and WB bypass
        drive(idle);
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); drive(lw2); #1;
        chk("b_lw_issue", act_b, E(0,0,0,0,0,0,0,0));
        @(negedge clk); drive(add3); #1;
        chk("b_stall1", act_b, E(0,1,0,1,0,0,0,0));
        @(negedge clk); #1;
        chk("b_stall2", act_b, E(0,1,0,1,0,0,0,0));
        @(negedge clk); #1;
        chk("b_release", act_b, E(0,0,0,0,0,0,0,0));
        @(negedge clk); drive(idle); #1;
        chk("b_fwd4", act_b, E(0,0,0,0,4,0,0,0));
        @(negedge clk); drive(xrd2); #1;
        chk("b_byp_wb", act_b, E(0,0,0,0,0,0,1,0));

        @(negedge clk); drive(idle);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
